serial_mag_comparator: RTL and testbench

//  Parametrised bit-serial magnitude comparator; successor to the 1-bit combinational comparator.

---
 rtl/serial_mag_comparator.sv | 95 +++++++++
 tb/tb_serial_mag_comparator.sv | 133 +++++++++++++
 2 files changed

// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator: bit-serial MSB-first magnitude comparator, unsigned or two's complement,
// with early exit on the first differing bit and a one-cycle done pulse.
module serial_mag_comparator #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);
    typedef enum logic {IDLE, CMP} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] xr, yr, xr_nx, yr_nx;
    logic [CNT_W-1:0] idx, idx_nx;
    logic             sm, sm_nx, busy_nx, done_nx, gt_nx, eq_nx, lt_nx;
    logic             xb, yb, inv;

    always_comb begin
        xb       = xr[idx];
        yb       = yr[idx];
        // a differing sign bit flips the ordering in two's complement
        inv      = sm && idx == CNT_W'(WIDTH - 1);
        state_nx = state;
        xr_nx    = xr;
        yr_nx    = yr;
        sm_nx    = sm;
        idx_nx   = idx;
        busy_nx  = busy;
        done_nx  = 1'b0;
        gt_nx    = gt;
        eq_nx    = eq;
        lt_nx    = lt;
        if (state == IDLE) begin
            if (start) begin
                xr_nx    = x;
                yr_nx    = y;
                sm_nx    = signed_mode;
                idx_nx   = CNT_W'(WIDTH - 1);
                busy_nx  = 1'b1;
                state_nx = CMP;
            end
        end else if (xb != yb) begin
            gt_nx    = inv ? yb : xb;
            lt_nx    = inv ? xb : yb;
            eq_nx    = 1'b0;
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
            state_nx = IDLE;
        end else if (idx == '0) begin
            gt_nx    = 1'b0;
            lt_nx    = 1'b0;
            eq_nx    = 1'b1;
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
            state_nx = IDLE;
        end else begin
            idx_nx = idx - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            xr    <= '0;
            yr    <= '0;
            sm    <= 1'b0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            gt    <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
        end else begin
            state <= state_nx;
            xr    <= xr_nx;
            yr    <= yr_nx;
            sm    <= sm_nx;
            idx   <= idx_nx;
            busy  <= busy_nx;
            done  <= done_nx;
            gt    <= gt_nx;
            eq    <= eq_nx;
            lt    <= lt_nx;
        end
    end
endmodule

// File: tb/tb_serial_mag_comparator.sv
// tb_serial_mag_comparator: directed and random checks of the serial comparator against
// an arithmetic model of ordering and first-difference latency.
module tb_serial_mag_comparator;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic         signed_mode = 1'b0;
    logic         busy, done, gt, eq, lt;
    int           tests = 0;
    int           fails = 0;

    serial_mag_comparator #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .signed_mode(signed_mode),
        .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int ia, ib;
        ia = s ? int'($signed(a)) : int'(a);
        ib = s ? int'($signed(b)) : int'(b);
        return {ia > ib, ia == ib, ia < ib};
    endfunction

    function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int i = W - 1; i >= 0; i--)
            if (a[i] != b[i]) return W - i;
        return W;
    endfunction

    // one operation; while busy, start is pulsed randomly with junk operands that must be ignored
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input string tag);
        logic [2:0] prev;
        int         n;
        prev = {gt, eq, lt};
        n = 0;
        @(negedge clk);
        x = a; y = b; signed_mode = s; start = 1'b1;
        @(posedge clk); #1;
        chk({tag, " busy_on"}, 32'(busy), 32'd1);
        while (!done && n < 3 * W) begin
            chk({tag, " held"}, 32'({gt, eq, lt, busy}), 32'({prev, 1'b1}));
            start = 1'($urandom);
            x = W'($urandom);
            y = W'($urandom);
            signed_mode = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk({tag, " latency"}, 32'(n), 32'(exp_lat(a, b)));
        chk({tag, " result"}, 32'({gt, eq, lt}), 32'(model(a, b, s)));
        chk({tag, " busy_off"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk({tag, " done_pulse"}, 32'({done, busy}), 32'd0);
        chk({tag, " result_held"}, 32'({gt, eq, lt}), 32'(model(a, b, s)));
    endtask

    logic [W-1:0] bx [4] = '{8'h10, 8'hC3, 8'h77, 8'h01};
    logic [W-1:0] by [4] = '{8'h10, 8'h43, 8'h70, 8'h81};
    logic         bs [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        int n;
        logic [W-1:0] a, b;
        #1;
        chk("reset", 32'({busy, done, gt, eq, lt}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle", 32'({busy, done, gt, eq, lt}), 32'd0);

        op(8'h5A, 8'h5A, 1'b0, "t1_eq");
        op(8'h80, 8'h7F, 1'b0, "t2_uns_msb");
        op(8'h80, 8'h7F, 1'b1, "t3_sgn_msb");
        op(8'h12, 8'h13, 1'b1, "t4_sgn_lt");
        op(8'hFF, 8'hFE, 1'b1, "t4_sgn_gt");
        op(8'd3, 8'd5, 1'b0, "t5_ignore");

        @(negedge clk);
        x = 8'h33; y = 8'h33; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("t5_abort", 32'({busy, done, gt, eq, lt}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 2) @(posedge clk);
        #1 chk("t5_no_done", 32'({busy, done, gt, eq, lt}), 32'd0);
        op(8'h21, 8'h20, 1'b0, "t5_after_rst");

        @(negedge clk);
        x = bx[0]; y = by[0]; signed_mode = bs[0]; start = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            if (i < 3) begin
                x = bx[i+1]; y = by[i+1]; signed_mode = bs[i+1];
            end else start = 1'b0;
            while (!done && n < 3 * W) begin
                @(posedge clk); #1;
                n++;
            end
            chk("t6_b2b_latency", 32'(n), 32'(exp_lat(bx[i], by[i])));
            chk("t6_b2b_result", 32'({gt, eq, lt}), 32'(model(bx[i], by[i], bs[i])));
            @(posedge clk); #1;
            chk("t6_b2b_next", 32'({done, busy}), (i < 3) ? 32'd1 : 32'd0);
        end

        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? a : W'($urandom);
            op(a, b, 1'($urandom), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
